// File: rtl/gb_cart_pkg.sv
// gb_cart_pkg
// Shared definitions for the cartridge bus front end and mapper:
//   - write-capture FSM state encoding (2 bits)
//   - Game Boy bus idle levels (WR/CS/RST are active low, idle high)
//   - write event field widths
//   - saturating increment helper for the small filter counter
package gb_cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_QUAL = 2'd2,
        ST_EMIT = 2'd3
    } gb_wr_state_t;

    localparam logic BUS_WR_IDLE  = 1'b1;
    localparam logic BUS_CS_IDLE  = 1'b1;
    localparam logic BUS_RST_IDLE = 1'b1;

    localparam int EV_ADDR_W  = 4;
    localparam int EV_DATA_W  = 8;
    localparam int FILT_CNT_W = 4;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [FILT_CNT_W-1:0] sat_inc(
        input logic [FILT_CNT_W-1:0] cnt,
        input logic [FILT_CNT_W-1:0] lim
    );
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/gb_bus_write_capture_if.sv
// gb_bus_write_capture_if
// Write event handshake between the bus capture front end (master) and
// the mapper register file (slave).
//   EV_VALID  master->slave  event pending
//   EV_READY  slave->master  event accepted this cycle
//   EV_ADDR   master->slave  captured A[15:12]
//   EV_DATA   master->slave  captured data byte
//   EV_CS     master->slave  captured GB_CS level
interface gb_bus_write_capture_if;

    logic                             EV_VALID;
    logic                             EV_READY;
    logic [gb_cart_pkg::EV_ADDR_W-1:0] EV_ADDR;
    logic [gb_cart_pkg::EV_DATA_W-1:0] EV_DATA;
    logic                             EV_CS;

    modport master (
        output EV_VALID,
        output EV_ADDR,
        output EV_DATA,
        output EV_CS,
        input  EV_READY
    );

    modport slave (
        input  EV_VALID,
        input  EV_ADDR,
        input  EV_DATA,
        input  EV_CS,
        output EV_READY
    );

endinterface

// File: rtl/gb_sync.sv
// gb_sync
// Multi-bit flip-flop synchronizer with an asynchronous preset value.
// Each bit is synchronized independently; grouped bits are only
// coherent when the source holds them stable across the sampling window.
//   clk  local clock
//   rst  asynchronous active-high reset, loads RESET_VAL into every stage
//   d    asynchronous input
//   q    output of the last stage
module gb_sync #(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gb_bus_write_capture.sv
// gb_bus_write_capture
// Samples the asynchronous Game Boy cartridge bus into the CLK domain,
// rejects short WR glitches and emits one held write event per qualified
// GB write cycle over a valid/ready handshake.
//
// Ports:
//   CLK, RST        local clock, asynchronous active-high reset
//   GB_A[3:0]       GB address bits 15:12 (async)
//   GB_D[7:0]       GB data bus (async)
//   GB_CS, GB_WR    chip select / write strobe, active low (async)
//   GB_RST          console reset, active low (async)
//   ev              event handshake (master side): EV_VALID/EV_READY,
//                   EV_ADDR, EV_DATA, EV_CS
//   OVERFLOW        sticky: a qualified write found the slot busy
//   OVERFLOW_CLR    clears OVERFLOW (a coincident drop wins)
//
// Optional build macro GB_WRITE_COUNT_EN adds:
//   WR_COUNT[15:0]     saturating count of emitted writes (incl. dropped)
//   GLITCH_COUNT[7:0]  saturating count of rejected WR glitches
module gb_bus_write_capture
    import gb_cart_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [EV_ADDR_W-1:0] GB_A,
    input  logic [EV_DATA_W-1:0] GB_D,
    input  logic                 GB_CS,
    input  logic                 GB_WR,
    input  logic                 GB_RST,
    gb_bus_write_capture_if.master ev,
    output logic                 OVERFLOW,
    input  logic                 OVERFLOW_CLR
`ifdef GB_WRITE_COUNT_EN
    ,
    output logic [15:0]          WR_COUNT,
    output logic [7:0]           GLITCH_COUNT
`endif
);

    localparam logic [FILT_CNT_W-1:0] FILT_LIM   = FILT_CNT_W'(FILTER_CYCLES);
    localparam logic [2:0]            SETTLE_LIM = 3'(SYNC_STAGES);

    logic                 wr_s;
    logic                 cs_s;
    logic                 grst_s;
    logic [EV_ADDR_W-1:0] a_s;
    logic [EV_DATA_W-1:0] d_s;

    // Synchronizer stage boundary: GB pins -> *_s
    gb_sync #(
        .WIDTH       (3),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   ({BUS_WR_IDLE, BUS_CS_IDLE, BUS_RST_IDLE})
    ) u_sync_ctrl (
        .clk (CLK),
        .rst (RST),
        .d   ({GB_WR, GB_CS, GB_RST}),
        .q   ({wr_s, cs_s, grst_s})
    );

    gb_sync #(
        .WIDTH       (EV_ADDR_W + EV_DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   ('0)
    ) u_sync_bus (
        .clk (CLK),
        .rst (RST),
        .d   ({GB_A, GB_D}),
        .q   ({a_s, d_s})
    );

    gb_wr_state_t          state_q;
    gb_wr_state_t          state_d;
    logic                  glitch;
    logic [FILT_CNT_W-1:0] filt_cnt_q;
    logic [2:0]            settle_cnt_q;
    logic                  armed_q;
    logic [EV_ADDR_W-1:0]  shadow_addr_q;
    logic [EV_DATA_W-1:0]  shadow_data_q;
    logic                  shadow_cs_q;
    logic                  ev_valid_q;
    logic [EV_ADDR_W-1:0]  ev_addr_q;
    logic [EV_DATA_W-1:0]  ev_data_q;
    logic                  ev_cs_q;
    logic                  overflow_q;
    logic                  emit;
    logic                  slot_free;

    // Filter counter, shadow capture and re-arm tracking
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            filt_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            armed_q       <= 1'b0;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
            shadow_cs_q   <= BUS_CS_IDLE;
        end else begin
            filt_cnt_q <= wr_s ? '0 : sat_inc(filt_cnt_q, FILT_LIM);

            // The synchronizer preset makes WR read idle right after reset.
            // A WR still held low from before reset would surface as a fake
            // falling edge once the preset flushes, so capture is only armed
            // after a genuine synchronized WR-high has been seen.
            if (settle_cnt_q != SETTLE_LIM) begin
                settle_cnt_q <= settle_cnt_q + 3'd1;
            end
            if (settle_cnt_q == SETTLE_LIM && wr_s) begin
                armed_q <= 1'b1;
            end

            // Loading on every low cycle leaves the last pre-rise sample,
            // which is where the GB latches its write.
            if (!wr_s) begin
                shadow_addr_q <= a_s;
                shadow_data_q <= d_s;
                shadow_cs_q   <= cs_s;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        glitch  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!wr_s && grst_s && armed_q) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (!grst_s) begin
                    state_d = ST_IDLE;
                end else if (filt_cnt_q == FILT_LIM) begin
                    state_d = ST_QUAL;
                end else if (wr_s) begin
                    state_d = ST_IDLE;
                    glitch  = 1'b1;
                end
            end
            ST_QUAL: begin
                if (!grst_s) begin
                    state_d = ST_IDLE;
                end else if (wr_s) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign emit      = (state_q == ST_EMIT);
    assign slot_free = !ev_valid_q || ev.EV_READY;

    // Output slot stage boundary: shadow -> EV_*
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ev_valid_q <= 1'b0;
            ev_addr_q  <= '0;
            ev_data_q  <= '0;
            ev_cs_q    <= BUS_CS_IDLE;
            overflow_q <= 1'b0;
        end else begin
            if (emit && slot_free) begin
                ev_valid_q <= 1'b1;
                ev_addr_q  <= shadow_addr_q;
                ev_data_q  <= shadow_data_q;
                ev_cs_q    <= shadow_cs_q;
            end else if (ev_valid_q && ev.EV_READY) begin
                ev_valid_q <= 1'b0;
            end

            if (emit && !slot_free) begin
                overflow_q <= 1'b1;
            end else if (OVERFLOW_CLR) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign ev.EV_VALID = ev_valid_q;
    assign ev.EV_ADDR  = ev_addr_q;
    assign ev.EV_DATA  = ev_data_q;
    assign ev.EV_CS    = ev_cs_q;
    assign OVERFLOW    = overflow_q;

`ifdef GB_WRITE_COUNT_EN
    logic [15:0] wr_count_q;
    logic [7:0]  glitch_count_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_count_q     <= '0;
            glitch_count_q <= '0;
        end else begin
            if (emit && wr_count_q != 16'hFFFF) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (glitch && glitch_count_q != 8'hFF) begin
                glitch_count_q <= glitch_count_q + 8'd1;
            end
        end
    end

    assign WR_COUNT     = wr_count_q;
    assign GLITCH_COUNT = glitch_count_q;
`endif

endmodule

// File: tb/tb_gb_bus_write_capture.sv
// tb_gb_bus_write_capture
// Scoreboard bench: every write the bench expects to be delivered is pushed
// into a queue when issued; a monitor pops and compares on each handshake.
module tb_gb_bus_write_capture;

    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int LAT   = SYNC + 2;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       cs;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] GB_A = '0;
    logic [7:0] GB_D = '0;
    logic       GB_CS = 1'b1;
    logic       GB_WR = 1'b1;
    logic       GB_RST = 1'b1;
    logic       OVERFLOW;
    logic       OVERFLOW_CLR = 1'b0;
`ifdef GB_WRITE_COUNT_EN
    logic [15:0] WR_COUNT;
    logic [7:0]  GLITCH_COUNT;
`endif

    gb_bus_write_capture_if ev_if ();

    gb_bus_write_capture #(
        .SYNC_STAGES   (SYNC),
        .FILTER_CYCLES (FILT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .GB_A         (GB_A),
        .GB_D         (GB_D),
        .GB_CS        (GB_CS),
        .GB_WR        (GB_WR),
        .GB_RST       (GB_RST),
        .ev           (ev_if),
        .OVERFLOW     (OVERFLOW),
        .OVERFLOW_CLR (OVERFLOW_CLR)
`ifdef GB_WRITE_COUNT_EN
        ,
        .WR_COUNT     (WR_COUNT),
        .GLITCH_COUNT (GLITCH_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  rnd_ready = 0;
    ev_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rnd_ready) ev_if.EV_READY = 1'($urandom_range(0, 1));
    endtask

    // A write qualifies when WR stays low for at least FILT cycles.
    function automatic bit qualifies(input int low);
        return low >= FILT;
    endfunction

    // One GB write cycle. lat returns the tick after the WR rise on which
    // EV_VALID was first seen (-1 if never). pulse_emit raises EV_READY for
    // exactly the cycle in which the new event is handed to the slot.
    task automatic gb_write(input logic [3:0] a, input logic [7:0] d, input logic cs,
                            input int low, input bit pulse_emit, output int lat);
        lat   = -1;
        GB_A  = a;
        GB_D  = d;
        GB_CS = cs;
        tick();
        GB_WR = 1'b0;
        repeat (low) tick();
        GB_WR = 1'b1;
        for (int k = 1; k <= LAT + 4; k++) begin
            tick();
            if (pulse_emit && k == LAT - 1) ev_if.EV_READY = 1'b1;
            if (pulse_emit && k == LAT)     ev_if.EV_READY = 1'b0;
            if (lat < 0 && ev_if.EV_VALID === 1'b1) lat = k;
            if (k == 2) GB_CS = 1'b1;
        end
    endtask

    task automatic wait_slot_free();
        int n = 0;
        while (ev_if.EV_VALID !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL slot_drain: EV_VALID still %0b after %0d cycles, required 0", ev_if.EV_VALID, n);
        end
    endtask

    initial begin
        int  lat;
        ev_t e;
        ev_if.EV_READY = 1'b0;

        fork
            begin : monitor
                ev_t x;
                forever begin
                    @(negedge CLK);
                    if (ev_if.EV_VALID === 1'b1 && ev_if.EV_READY === 1'b1) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_event: got addr %0h data %0h cs %0b, required none",
                                     ev_if.EV_ADDR, ev_if.EV_DATA, ev_if.EV_CS);
                        end else begin
                            x = sb.pop_front();
                            check("ev_addr", 32'(ev_if.EV_ADDR), 32'(x.a));
                            check("ev_data", 32'(ev_if.EV_DATA), 32'(x.d));
                            check("ev_cs",   32'(ev_if.EV_CS),   32'(x.cs));
                        end
                    end
                end
            end
            begin : watchdog
                #500000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_valid",    32'(ev_if.EV_VALID), 32'h0);
        check("rst_addr",     32'(ev_if.EV_ADDR),  32'h0);
        check("rst_data",     32'(ev_if.EV_DATA),  32'h0);
        check("rst_cs",       32'(ev_if.EV_CS),    32'h1);
        check("rst_overflow", 32'(OVERFLOW),       32'h0);
        RST = 1'b0;
        repeat (6) tick();

        // Glitch rejection
        ev_if.EV_READY = 1'b1;
        gb_write(4'h1, 8'hEE, 1'b0, 2, 0, lat);
        check("glitch_no_event", 32'(lat), 32'hFFFF_FFFF);
`ifdef GB_WRITE_COUNT_EN
        check("glitch_count", 32'(GLITCH_COUNT), 32'd1);
        check("wr_count",     32'(WR_COUNT),     32'd0);
`endif

        // Basic write with latency
        sb.push_back('{a: 4'h2, d: 8'h05, cs: 1'b1});
        gb_write(4'h2, 8'h05, 1'b1, 20, 0, lat);
        check("basic_latency", 32'(lat), 32'(LAT));
        check("basic_single_pulse", 32'(ev_if.EV_VALID), 32'h0);

        // Backpressure and overflow
        ev_if.EV_READY = 1'b0;
        sb.push_back('{a: 4'h0, d: 8'h0A, cs: 1'b0});
        gb_write(4'h0, 8'h0A, 1'b0, 20, 0, lat);
        gb_write(4'h4, 8'h33, 1'b0, 20, 0, lat);   // slot busy, ready low: dropped
        check("bp_valid_held", 32'(ev_if.EV_VALID), 32'h1);
        check("bp_addr_held",  32'(ev_if.EV_ADDR),  32'h0);
        check("bp_data_held",  32'(ev_if.EV_DATA),  32'h0A);
        check("bp_overflow",   32'(OVERFLOW),       32'h1);
        ev_if.EV_READY = 1'b1;
        repeat (8) tick();
        check("bp_drained", 32'(ev_if.EV_VALID), 32'h0);
        check("bp_overflow_sticky", 32'(OVERFLOW), 32'h1);
        OVERFLOW_CLR = 1'b1;
        tick();
        OVERFLOW_CLR = 1'b0;
        tick();
        check("ovf_cleared", 32'(OVERFLOW), 32'h0);

        // Same-cycle accept and load
        ev_if.EV_READY = 1'b0;
        sb.push_back('{a: 4'h7, d: 8'h21, cs: 1'b0});
        gb_write(4'h7, 8'h21, 1'b0, 20, 0, lat);
        sb.push_back('{a: 4'h3, d: 8'h01, cs: 1'b1});
        gb_write(4'h3, 8'h01, 1'b1, 20, 1, lat);
        check("sc_valid", 32'(ev_if.EV_VALID), 32'h1);
        check("sc_addr",  32'(ev_if.EV_ADDR),  32'h3);
        check("sc_data",  32'(ev_if.EV_DATA),  32'h01);
        check("sc_ovf",   32'(OVERFLOW),       32'h0);
        ev_if.EV_READY = 1'b1;
        repeat (4) tick();

        // Console reset blocks a full write
        GB_RST = 1'b0;
        repeat (3) tick();
        gb_write(4'h1, 8'h11, 1'b0, 20, 0, lat);
        check("grst_no_event", 32'(lat), 32'hFFFF_FFFF);
        GB_RST = 1'b1;
        repeat (4) tick();

        // Console reset leaves a pending event alone
        ev_if.EV_READY = 1'b0;
        sb.push_back('{a: 4'h6, d: 8'h66, cs: 1'b1});
        gb_write(4'h6, 8'h66, 1'b1, 20, 0, lat);
        GB_RST = 1'b0;
        repeat (6) tick();
        GB_RST = 1'b1;
        repeat (4) tick();
        check("grst_keep_valid", 32'(ev_if.EV_VALID), 32'h1);
        check("grst_keep_addr",  32'(ev_if.EV_ADDR),  32'h6);
        check("grst_keep_data",  32'(ev_if.EV_DATA),  32'h66);
        ev_if.EV_READY = 1'b1;
        repeat (3) tick();

        // Reset during a write in QUAL; a held event and OVERFLOW are wiped
        ev_if.EV_READY = 1'b0;
        gb_write(4'h5, 8'h77, 1'b0, 20, 0, lat);
        gb_write(4'h5, 8'h78, 1'b0, 20, 0, lat);
        check("pre_rst_overflow", 32'(OVERFLOW), 32'h1);
        GB_A  = 4'h9;
        GB_D  = 8'h99;
        GB_CS = 1'b0;
        tick();
        GB_WR = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ev_if.EV_VALID), 32'h0);
        check("mid_rst_addr",  32'(ev_if.EV_ADDR),  32'h0);
        check("mid_rst_data",  32'(ev_if.EV_DATA),  32'h0);
        check("mid_rst_cs",    32'(ev_if.EV_CS),    32'h1);
        check("mid_rst_ovf",   32'(OVERFLOW),       32'h0);
        tick();
        RST = 1'b0;
        ev_if.EV_READY = 1'b1;
        repeat (6) tick();
        GB_WR = 1'b1;
        GB_CS = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (lat < 0 && ev_if.EV_VALID === 1'b1) lat = k;
        end
        check("mid_rst_no_event", 32'(lat), 32'hFFFF_FFFF);
        sb.push_back('{a: 4'hA, d: 8'h5A, cs: 1'b1});
        gb_write(4'hA, 8'h5A, 1'b1, 20, 0, lat);
        check("post_rst_latency", 32'(lat), 32'(LAT));

        // Randomized writes with random backpressure; slot drained first
        rnd_ready = 1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            logic [7:0] d;
            logic       cs;
            int         low;
            wait_slot_free();
            a   = 4'($urandom_range(0, 15));
            d   = 8'($urandom_range(0, 255));
            cs  = 1'($urandom_range(0, 1));
            low = $urandom_range(1, 10);
            if (qualifies(low)) begin
                e = '{a: a, d: d, cs: cs};
                sb.push_back(e);
            end
            gb_write(a, d, cs, low, 0, lat);
        end
        rnd_ready = 0;
        ev_if.EV_READY = 1'b1;
        repeat (10) tick();

        check("sb_empty", 32'(sb.size()), 32'h0);
        check("final_ovf", 32'(OVERFLOW), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_bus_write_capture.md
Name: gb_bus_write_capture

Overview:
- Upstream front end for the cartridge mapper register file.
- Samples the asynchronous Game Boy bus (GB_A[15:12], GB_D, GB_CS, GB_WR, GB_RST) into the local CLK domain and rejects WR glitches.
- Emits one clean, held write event per qualified GB write cycle: address nibble, data byte and CS state.
- The mapper consumes events over a valid/ready handshake, so its bank registers become synchronous instead of being clocked by decoded strobes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of every input synchronizer (legal values 2..4).
- FILTER_CYCLES, 4, minimum number of consecutive synchronized-low WR cycles for a write to qualify (legal values 1..15).

Ports:
- CLK  input  1  local clock, rising edge; at least 16x the GB bus rate.
- RST  input  1  asynchronous active-high reset.
- GB_A  input  4  GB address bits 15:12, asynchronous.
- GB_D  input  8  GB data bus, asynchronous.
- GB_CS  input  1  GB chip select, active low, asynchronous.
- GB_WR  input  1  GB write strobe, active low, asynchronous.
- GB_RST  input  1  GB console reset, active low, asynchronous.
- EV_VALID  output  1  write event pending.
- EV_READY  input  1  consumer accepts the event.
- EV_ADDR  output  4  captured A[15:12].
- EV_DATA  output  8  captured data byte.
- EV_CS  output  1  captured GB_CS level (0 = A000-FFFF region access).
- OVERFLOW  output  1  sticky flag: a qualified write was dropped.
- OVERFLOW_CLR  input  1  clears OVERFLOW.

Behaviour:
- Reset (RST=1, asynchronous):
  - Synchronizers preset to bus-idle: WR=1, CS=1, GB_RST=1, A=0, D=0.
  - FSM to IDLE; filter counter=0; EV_VALID=0; EV_ADDR=0; EV_DATA=0; EV_CS=1; OVERFLOW=0.
- Synchronization: every GB input passes through SYNC_STAGES flops. wr_s, cs_s, a_s, d_s and grst_s are the final-stage values.
- Filter counter: 4 bits. It increments while wr_s=0, saturates at FILTER_CYCLES, and clears while wr_s=1.
- Shadow capture: shadow address, data and CS registers load a_s, d_s and cs_s on every cycle that wr_s=0. They therefore hold the last sample taken before the WR rising edge, which matches the GB latch point.
- FSM states:
  - IDLE: if wr_s=0 and grst_s=1, go to LOW.
  - LOW: counting. If the count reaches FILTER_CYCLES, go to QUAL. If wr_s=1 first, go to IDLE with no event (glitch rejected).
  - QUAL: on wr_s=1 (rising edge), go to EMIT.
  - EMIT: lasts one cycle. Hands the shadow registers to the output slot, then goes to IDLE.
- Event latency: EV_VALID rises 1 cycle after EMIT, i.e. SYNC_STAGES+2 CLK cycles after the GB_WR pin rises.
- Output slot:
  - EV_VALID, EV_ADDR, EV_DATA and EV_CS are registered.
  - They are held stable while EV_VALID=1 and EV_READY=0.
  - EV_VALID clears on the cycle after EV_VALID&EV_READY.
- EMIT while the slot is occupied:
  - With EV_READY=1 in the same cycle, the new event loads and EV_VALID stays 1 (no bubble, no overflow).
  - With EV_READY=0, the new event is discarded, the old event is retained, and OVERFLOW is set.
- OVERFLOW: cleared by OVERFLOW_CLR. If set and clear coincide, set wins.
- Console reset: grst_s=0 forces the FSM to IDLE from any state and blocks LOW entry. The pending slot and OVERFLOW are unaffected.
- Reset mid-operation: RST during LOW or QUAL aborts the cycle with no event. The next event requires a fresh WR falling edge after RST is released.
- EV_READY is ignored while EV_VALID=0.

Optional Feature:
- Macro: GB_WRITE_COUNT_EN.
- When defined:
  - Adds output WR_COUNT [15:0], a saturating count of EMIT events including dropped ones; reset 0.
  - Adds output GLITCH_COUNT [7:0], a saturating count of LOW->IDLE rejections; reset 0.
- When undefined: neither port nor its counters exist, and all other behaviour is identical.

Decomposition:
- Shared package gb_cart_pkg:
  - FSM state encoding (IDLE, LOW, QUAL, EMIT; 2 bits).
  - Bus idle constants (WR/CS idle = 1).
  - Event field widths (address 4, data 8).
- Sub-module gb_sync: a parameterized SYNC_STAGES multi-bit synchronizer with a reset preset value. It is instantiated for the control bits and for the address/data group.

Test Plan:
- Basic write: GB_A=2, GB_D=0x05, GB_WR low 20 cycles then high, EV_READY=1 -> exactly one EV_VALID pulse 4 cycles after the WR rise, EV_ADDR=2, EV_DATA=0x05, EV_CS=1.
- Glitch rejection: GB_WR low 2 cycles (FILTER_CYCLES=4) -> no EV_VALID; with GB_WRITE_COUNT_EN, GLITCH_COUNT=1 and WR_COUNT=0.
- Backpressure and overflow: EV_READY=0; write 0x0A to addr 0, then 0x33 to addr 4 -> EV_ADDR=0 and EV_DATA=0x0A held, OVERFLOW=1. Raise EV_READY -> EV_VALID drops and no second event appears. Pulse OVERFLOW_CLR -> OVERFLOW=0.
- Same-cycle accept and load: hold the first event, assert EV_READY exactly on the EMIT cycle of a second write (0x3000, 0x01) -> EV_VALID stays 1, outputs switch to ADDR=3, DATA=0x01, OVERFLOW=0.
- Reset during a write: assert RST for 1 cycle while the FSM is in QUAL, then release WR -> no event, all outputs at reset values. The next full write produces a normal event.
- Console reset: GB_RST=0 during a full 20-cycle write -> no event. With GB_RST=1 and an event already pending, pulsing GB_RST=0 leaves the event unchanged.
